// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one external byte-wide ROM/SDRAM port between the
// ROM downloader (writes) and three readers (video, CPU, sound).
// Priority per pick: latched download > video > CPU/sound round-robin.
// Sequence per access: IDLE (pick) -> ISSUE (strobe) -> WAIT -> DONE (ack next cycle).
//
// Handshake: a reader holds *_req high with a stable *_addr. Once granted, the
// access always completes. The requester then sees a single-cycle *_ack, and
// *_data is valid from that cycle until its next ack. A request still high in
// the ack cycle is granted again. The downloader pulses dl_en once, and dl_busy
// stays high until the write has finished.
module rom_port_arbiter #(
  parameter int AW  = 18,
  parameter int DW  = 8,
  parameter int TMO = 15
) (
  input  logic          clk48M,
  input  logic          reset_n,
  input  logic          pause,
  input  logic          dl_en,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_busy,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_data,
  input  logic          snd_req,
  input  logic [AW-1:0] snd_addr,
  output logic          snd_ack,
  output logic [DW-1:0] snd_data,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          tmo_flag,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_DL, G_VID, G_CPU, G_SND} grant_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  logic          rr_q, rr_d;              // 0: CPU preferred, 1: sound preferred
  logic          dl_full_q, dl_full_d;
  logic [AW-1:0] dl_addr_q, dl_addr_d;
  logic [DW-1:0] dl_data_q, dl_data_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic [DW-1:0] cpu_data_q, cpu_data_d;
  logic [DW-1:0] snd_data_q, snd_data_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          snd_ack_q, snd_ack_d;
  logic          cpu_ok, snd_ok;
  logic [DW-1:0] cap_data;

  // Next-state, grant selection, download latch and completion data.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    dl_full_d  = dl_full_q;
    dl_addr_d  = dl_addr_q;
    dl_data_d  = dl_data_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_rd_d   = 1'b0;
    mem_we_d   = 1'b0;
    cnt_d      = cnt_q;
    tmo_flag_d = tmo_flag_q;
    vid_data_d = vid_data_q;
    cpu_data_d = cpu_data_q;
    snd_data_d = snd_data_q;
    vid_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    snd_ack_d  = 1'b0;
    cpu_ok     = cpu_req && !pause;
    snd_ok     = snd_req && !pause;
    // A timed-out read returns all ones so the requester can never stall.
    cap_data   = mem_ready ? mem_rdata : {DW{1'b1}};

    // A strobe arriving while the latch is full is dropped.
    if (dl_en && !dl_full_q) begin
      dl_full_d = 1'b1;
      dl_addr_d = dl_addr;
      dl_data_d = dl_data;
    end

    case (state_q)
      S_IDLE: begin
        if (dl_full_q) begin
          grant_d    = G_DL;
          mem_addr_d = dl_addr_q;
          mem_wd_d   = dl_data_q;
          mem_we_d   = 1'b1;
          state_d    = S_ISSUE;
        end else if (vid_req) begin
          grant_d    = G_VID;
          mem_addr_d = vid_addr;
          mem_rd_d   = 1'b1;
          state_d    = S_ISSUE;
        end else if (cpu_ok && (!snd_ok || !rr_q)) begin
          grant_d    = G_CPU;
          mem_addr_d = cpu_addr;
          mem_rd_d   = 1'b1;
          state_d    = S_ISSUE;
        end else if (snd_ok) begin
          grant_d    = G_SND;
          mem_addr_d = snd_addr;
          mem_rd_d   = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready || (cnt_q == TMO_LAST)) begin
          case (grant_q)
            G_VID:   vid_data_d = cap_data;
            G_CPU:   cpu_data_d = cap_data;
            G_SND:   snd_data_d = cap_data;
            default: ;
          endcase
          if (!mem_ready) tmo_flag_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        case (grant_q)
          G_DL:  dl_full_d = 1'b0;
          G_VID: vid_ack_d = 1'b1;
          G_CPU: begin
            cpu_ack_d = 1'b1;
            rr_d      = 1'b1;
          end
          G_SND: begin
            snd_ack_d = 1'b1;
            rr_d      = 1'b0;
          end
          default: ;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access without an ack.
  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= G_DL;
      rr_q       <= 1'b0;
      dl_full_q  <= 1'b0;
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cnt_q      <= 8'd0;
      tmo_flag_q <= 1'b0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
      snd_data_q <= '0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      snd_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      dl_full_q  <= dl_full_d;
      dl_addr_q  <= dl_addr_d;
      dl_data_q  <= dl_data_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_rd_q   <= mem_rd_d;
      mem_we_q   <= mem_we_d;
      cnt_q      <= cnt_d;
      tmo_flag_q <= tmo_flag_d;
      vid_data_q <= vid_data_d;
      cpu_data_q <= cpu_data_d;
      snd_data_q <= snd_data_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      snd_ack_q  <= snd_ack_d;
    end
  end

  assign dl_busy   = dl_full_q;
  assign vid_ack   = vid_ack_q;
  assign vid_data  = vid_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_data  = cpu_data_q;
  assign snd_ack   = snd_ack_q;
  assign snd_data  = snd_data_q;
  assign mem_rd    = mem_rd_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign tmo_flag  = tmo_flag_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: a memory responder, an ack scoreboard and one
// task per scenario.
module tb_rom_port_arbiter;

  logic        clk48M = 1'b0;
  logic        reset_n, pause, dl_en, dl_busy;
  logic [17:0] dl_addr, vid_addr, cpu_addr, snd_addr, mem_addr;
  logic [7:0]  dl_data, vid_data, cpu_data, snd_data, mem_wd, mem_rdata;
  logic        vid_req, vid_ack, cpu_req, cpu_ack, snd_req, snd_ack;
  logic        mem_rd, mem_we, mem_ready, tmo_flag;
  logic [1:0]  state_dbg;

  int          total = 0;
  int          bad   = 0;
  logic [9:0]  exp_q[$];      // {requester id (1 vid, 2 cpu, 3 snd), data}

  int          rsp_mode = 0;  // 0: never answer, 1: answer after rsp_lat cycles
  int          rsp_lat  = 1;
  bit          use_force = 1'b0;
  logic [7:0]  force_val = 8'h00;

  always #5 clk48M = ~clk48M;

  rom_port_arbiter #(.AW(18), .DW(8), .TMO(15)) dut (
    .clk48M(clk48M), .reset_n(reset_n), .pause(pause),
    .dl_en(dl_en), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .snd_req(snd_req), .snd_addr(snd_addr), .snd_ack(snd_ack), .snd_data(snd_data),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .tmo_flag(tmo_flag),
    .state_dbg(state_dbg)
  );

  function automatic logic [7:0] mem_model(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]};
  endfunction

  // Memory responder: raises mem_ready for one cycle rsp_lat cycles after a strobe.
  initial begin : responder
    logic [17:0] a;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk48M);
      if (reset_n && (mem_rd || mem_we) && rsp_mode == 1) begin
        a = mem_addr;
        repeat (rsp_lat) @(negedge clk48M);
        mem_ready = 1'b1;
        mem_rdata = use_force ? force_val : mem_model(a);
        @(negedge clk48M);
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
      end
    end
  end

  // Scoreboard: every ack pops the oldest expectation.
  initial begin : monitor
    logic [1:0] id;
    logic [7:0] d;
    logic [9:0] e;
    forever begin
      @(posedge clk48M); #1;
      if (reset_n && (vid_ack || cpu_ack || snd_ack)) begin
        total++;
        if ($countones({vid_ack, cpu_ack, snd_ack}) != 1) begin
          bad++;
          $display("FAIL ack_onehot got vid=%b cpu=%b snd=%b required exactly one", vid_ack, cpu_ack, snd_ack);
        end
        id = vid_ack ? 2'd1 : (cpu_ack ? 2'd2 : 2'd3);
        d  = vid_ack ? vid_data : (cpu_ack ? cpu_data : snd_data);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected got id=%0d data=%h required no ack", id, d);
        end else begin
          e = exp_q.pop_front();
          if ({id, d} !== e) begin
            bad++;
            $display("FAIL ack_order got id=%0d data=%h required id=%0d data=%h", id, d, e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk48M);
    reset_n  = 1'b0;
    pause    = 1'b0;
    dl_en    = 1'b0;
    dl_addr  = '0;
    dl_data  = '0;
    vid_req  = 1'b0;
    cpu_req  = 1'b0;
    snd_req  = 1'b0;
    vid_addr = '0;
    cpu_addr = '0;
    snd_addr = '0;
    repeat (3) @(negedge clk48M);
    reset_n = 1'b1;
  endtask

  // Bounded wait for one ack (1 vid, 2 cpu, 3 snd); returns at posedge+1 of the ack cycle.
  task automatic wait_ack(input int which, input int budget, output int cyc, output bit ok);
    logic hit;
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < budget) begin
      @(posedge clk48M); #1;
      cyc++;
      case (which)
        1:       hit = vid_ack;
        2:       hit = cpu_ack;
        default: hit = snd_ack;
      endcase
      if (hit) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pause = 1'b0; dl_en = 1'b0; dl_addr = '0; dl_data = '0;
    vid_req = 1'b0; cpu_req = 1'b0; snd_req = 1'b0;
    vid_addr = '0; cpu_addr = '0; snd_addr = '0;
    repeat (2) @(negedge clk48M);
    total++;
    if ({mem_rd, mem_we, dl_busy, tmo_flag, vid_ack, cpu_ack, snd_ack} !== 7'b0) begin
      bad++;
      $display("FAIL reset_strobes got %b required 0000000", {mem_rd, mem_we, dl_busy, tmo_flag, vid_ack, cpu_ack, snd_ack});
    end
    total++;
    if ({mem_addr, mem_wd} !== 26'h0) begin
      bad++;
      $display("FAIL reset_mem_bus got addr=%h wd=%h required 0", mem_addr, mem_wd);
    end
    total++;
    if ({vid_data, cpu_data, snd_data} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data got %h required 000000", {vid_data, cpu_data, snd_data});
    end
    reset_n = 1'b1;
    @(negedge clk48M);
    total++;
    if (state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got %0d required 0", state_dbg);
    end
  endtask

  task automatic test_single_video();
    int cyc, rd_cnt;
    logic [17:0] rd_addr;
    bit got;
    apply_reset();
    rsp_mode = 1; rsp_lat = 2; use_force = 1'b1; force_val = 8'h5A;
    exp_q.push_back({2'd1, 8'h5A});
    vid_addr = 18'h01234;
    vid_req  = 1'b1;
    cyc = 0; rd_cnt = 0; got = 1'b0; rd_addr = '0;
    while (!got && cyc < 30) begin
      @(posedge clk48M); #1;
      cyc++;
      if (mem_rd) begin
        rd_cnt++;
        rd_addr = mem_addr;
      end
      if (vid_ack) got = 1'b1;
    end
    @(negedge clk48M);
    vid_req = 1'b0;
    use_force = 1'b0;
    total++;
    if (!got || cyc != 5) begin
      bad++;
      $display("FAIL t1_latency got %0d (ack=%b) required 5", cyc, got);
    end
    total++;
    if (rd_cnt != 1) begin
      bad++;
      $display("FAIL t1_rd_count got %0d required 1", rd_cnt);
    end
    total++;
    if (rd_addr !== 18'h01234) begin
      bad++;
      $display("FAIL t1_rd_addr got %h required 01234", rd_addr);
    end
    total++;
    if (vid_data !== 8'h5A) begin
      bad++;
      $display("FAIL t1_vid_data got %h required 5a", vid_data);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    bit ok;
    apply_reset();
    rsp_mode = 1; rsp_lat = 1;
    exp_q.push_back({2'd2, mem_model(18'h00010)});
    exp_q.push_back({2'd3, mem_model(18'h20010)});
    exp_q.push_back({2'd1, mem_model(18'h01000)});
    exp_q.push_back({2'd2, mem_model(18'h00010)});
    exp_q.push_back({2'd3, mem_model(18'h20010)});
    cpu_addr = 18'h00010; snd_addr = 18'h20010;
    cpu_req = 1'b1; snd_req = 1'b1;
    wait_ack(2, 20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_cpu1 got no ack required ack"); end
    repeat (2) @(negedge clk48M);
    vid_addr = 18'h01000;
    vid_req  = 1'b1;
    wait_ack(3, 20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_snd1 got no ack required ack"); end
    wait_ack(1, 20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_vid got no ack required ack"); end
    @(negedge clk48M);
    vid_req = 1'b0;
    wait_ack(2, 20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_cpu2 got no ack required ack"); end
    wait_ack(3, 20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_snd2 got no ack required ack"); end
    @(negedge clk48M);
    cpu_req = 1'b0; snd_req = 1'b0;
    repeat (5) @(negedge clk48M);
  endtask

  task automatic test_download();
    int cyc, ack_cyc, we_cnt, we_cyc, busy_low;
    logic [17:0] we_addr;
    logic [7:0]  we_data;
    apply_reset();
    rsp_mode = 1; rsp_lat = 3;
    exp_q.push_back({2'd2, mem_model(18'h00200)});
    cpu_addr = 18'h00200;
    cpu_req  = 1'b1;
    repeat (2) @(negedge clk48M);
    dl_en = 1'b1; dl_addr = 18'h3FFFF; dl_data = 8'hC3;
    @(negedge clk48M);
    dl_en = 1'b0;
    total++;
    if (dl_busy !== 1'b1) begin
      bad++;
      $display("FAIL t3_busy_set got %b required 1", dl_busy);
    end
    @(negedge clk48M);
    dl_en = 1'b1; dl_addr = 18'h00001; dl_data = 8'h11;  // latch full: dropped
    @(negedge clk48M);
    dl_en = 1'b0;
    cyc = 0; ack_cyc = 0; we_cnt = 0; we_cyc = 0; busy_low = 0;
    we_addr = '0; we_data = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk48M); #1;
      cyc++;
      if (mem_we) begin
        we_cnt++;
        we_cyc  = cyc;
        we_addr = mem_addr;
        we_data = mem_wd;
      end
      if (!dl_busy && busy_low == 0 && we_cnt > 0) busy_low = cyc;
      if (cpu_ack) begin
        if (ack_cyc == 0) ack_cyc = cyc;
        @(negedge clk48M);
        cpu_req = 1'b0;
      end
    end
    total++;
    if (ack_cyc == 0 || we_cyc <= ack_cyc) begin
      bad++;
      $display("FAIL t3_order got ack_cyc=%0d we_cyc=%0d required ack before write", ack_cyc, we_cyc);
    end
    total++;
    if (we_cnt != 1) begin
      bad++;
      $display("FAIL t3_we_count got %0d required 1", we_cnt);
    end
    total++;
    if (we_addr !== 18'h3FFFF || we_data !== 8'hC3) begin
      bad++;
      $display("FAIL t3_write got addr=%h data=%h required 3ffff c3", we_addr, we_data);
    end
    total++;
    if (busy_low == 0 || busy_low <= we_cyc) begin
      bad++;
      $display("FAIL t3_busy_clear got low_cyc=%0d we_cyc=%0d required clear after write", busy_low, we_cyc);
    end
  endtask

  task automatic test_pause();
    int cyc, rd_cnt;
    bit ok;
    apply_reset();
    rsp_mode = 1; rsp_lat = 1;
    pause = 1'b1;
    cpu_addr = 18'h00010; snd_addr = 18'h20010;
    cpu_req = 1'b1; snd_req = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk48M); #1;
      if (mem_rd) rd_cnt++;
    end
    total++;
    if (rd_cnt != 0) begin
      bad++;
      $display("FAIL t4_paused_rd got %0d required 0", rd_cnt);
    end
    @(negedge clk48M);
    exp_q.push_back({2'd1, mem_model(18'h00333)});
    vid_addr = 18'h00333;
    vid_req  = 1'b1;
    wait_ack(1, 20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t4_vid got no ack required ack"); end
    @(negedge clk48M);
    vid_req = 1'b0;
    repeat (3) @(negedge clk48M);
    exp_q.push_back({2'd2, mem_model(18'h00010)});
    pause = 1'b0;
    wait_ack(2, 20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t4_cpu_first got no cpu ack required ack"); end
    @(negedge clk48M);
    cpu_req = 1'b0; snd_req = 1'b0;
    repeat (5) @(negedge clk48M);
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    apply_reset();
    rsp_mode = 0;
    exp_q.push_back({2'd2, 8'hFF});
    cpu_addr = 18'h00444;
    cpu_req  = 1'b1;
    wait_ack(2, 40, cyc, ok);
    @(negedge clk48M);
    cpu_req = 1'b0;
    total++;
    if (!ok || cyc != 18) begin
      bad++;
      $display("FAIL t5_latency got %0d (ack=%b) required 18", cyc, ok);
    end
    total++;
    if (cpu_data !== 8'hFF) begin
      bad++;
      $display("FAIL t5_data got %h required ff", cpu_data);
    end
    total++;
    if (tmo_flag !== 1'b1) begin
      bad++;
      $display("FAIL t5_flag got %b required 1", tmo_flag);
    end
    repeat (20) @(negedge clk48M);
    total++;
    if (tmo_flag !== 1'b1) begin
      bad++;
      $display("FAIL t5_flag_sticky got %b required 1", tmo_flag);
    end
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    bit ok;
    apply_reset();
    total++;
    if (tmo_flag !== 1'b0) begin
      bad++;
      $display("FAIL t6_flag_cleared got %b required 0", tmo_flag);
    end
    rsp_mode = 0;
    cpu_addr = 18'h0ABCD;
    cpu_req  = 1'b1;
    repeat (3) @(negedge clk48M);
    total++;
    if (state_dbg !== 2'd2) begin
      bad++;
      $display("FAIL t6_in_wait got %0d required 2", state_dbg);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({mem_rd, mem_we, vid_ack, cpu_ack, snd_ack} !== 5'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL t6_async_clear got strobes=%b state=%0d required 00000 0", {mem_rd, mem_we, vid_ack, cpu_ack, snd_ack}, state_dbg);
    end
    rsp_mode = 1; rsp_lat = 1;
    exp_q.push_back({2'd2, mem_model(18'h0ABCD)});
    repeat (2) @(negedge clk48M);
    reset_n = 1'b1;
    wait_ack(2, 20, cyc, ok);
    @(negedge clk48M);
    cpu_req = 1'b0;
    total++;
    if (!ok || cyc != 4) begin
      bad++;
      $display("FAIL t6_regrant got %0d (ack=%b) required 4", cyc, ok);
    end
    repeat (5) @(negedge clk48M);
  endtask

  initial begin
    test_reset();
    test_single_video();
    test_round_robin();
    test_download();
    test_pause();
    test_timeout();
    test_reset_mid_access();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
